// File: rtl/data_memory_ctrl.sv
// Parametrised synchronous data memory with a registered read and valid strobe.
// Includes an address range check and a hardware zero-fill after reset or on clear.
module data_memory_ctrl #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 8,
   parameter int DEPTH          = 31,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] writeData,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic                  clear,
   output logic [DATA_WIDTH-1:0] dataOut,
   output logic                  dataValid,
   output logic                  addrError,
   output logic                  ready
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [IW-1:0] LP_LAST = IW'(DEPTH - 1);

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_IDLE  = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [IW-1:0]         r_ptr;
   logic                  r_fill_en;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_dout;
   logic                  r_valid;
   logic                  r_err;

   logic                  w_acc;
   logic                  w_rd;
   logic                  w_inrange;
   logic [IW-1:0]         w_idx;
   logic                  w_fill;
   logic                  w_we;
   logic [IW-1:0]         w_waddr;
   logic [DATA_WIDTH-1:0] w_wdata;

   // Full-width compare so out-of-range addresses never alias onto real words
   assign w_inrange = ({1'b0, address} < LP_DEPTH);
   assign w_idx     = address[IW-1:0];
   assign w_acc     = ready & (MemRead | MemWrite);
   assign w_rd      = w_acc & MemRead;
   assign w_fill    = (r_state == S_CLEAR) & r_fill_en;

   // Single write port shared by the fill engine and normal writes
   assign w_we    = w_fill | (w_acc & MemWrite & w_inrange);
   assign w_waddr = w_fill ? r_ptr : w_idx;
   assign w_wdata = w_fill ? '0 : writeData;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_CLEAR;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_CLEAR: begin
            if (!r_fill_en || (r_ptr == LP_LAST)) begin
               w_next = S_IDLE;
            end
         end
         S_IDLE: begin
            if (clear) begin
               w_next = S_CLEAR;
            end
         end
         default: w_next = S_CLEAR;
      endcase
   end

   always_comb begin
      ready = (r_state == S_IDLE);
   end

   // A clear request always fills, even when the post-reset fill is skipped
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr     <= '0;
         r_fill_en <= (CLEAR_ON_RESET != 0);
      end else if ((r_state == S_IDLE) && clear) begin
         r_ptr     <= '0;
         r_fill_en <= 1'b1;
      end else if (w_fill) begin
         r_ptr <= r_ptr + IW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (w_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_dout  <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_valid <= w_rd;
         r_err   <= w_acc & ~w_inrange;
         if (w_rd) begin
            if (!w_inrange) begin
               r_dout <= '0;
            end else if (MemWrite) begin
               r_dout <= writeData;
            end else begin
               r_dout <= r_mem[w_idx];
            end
         end
      end
   end

   assign dataOut   = r_dout;
   assign dataValid = r_valid;
   assign addrError = r_err;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed vector bench for data_memory_ctrl.
// Covers the reset fill, read/write, the range check, clear and async reset aborts.
module tb_data_memory_ctrl;

   logic       clock;
   logic       reset_n;
   logic [7:0] address;
   logic [7:0] writeData;
   logic       MemRead;
   logic       MemWrite;
   logic       clear;
   logic [7:0] dataOut;
   logic       dataValid;
   logic       addrError;
   logic       ready;

   int n_checks = 0;
   int n_err    = 0;

   data_memory_ctrl #(
      .DATA_WIDTH     (8),
      .ADDR_WIDTH     (8),
      .DEPTH          (31),
      .CLEAR_ON_RESET (1)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .address   (address),
      .writeData (writeData),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .clear     (clear),
      .dataOut   (dataOut),
      .dataValid (dataValid),
      .addrError (addrError),
      .ready     (ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic       rd;
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic       valid;
      logic       err;
      logic [7:0] dout;
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rd, input logic wr,
                        input logic [7:0] a, input logic [7:0] d);
      MemRead   = rd;
      MemWrite  = wr;
      address   = a;
      writeData = d;
   endtask

   // Count sampled cycles with ready low; bounded so a stuck fill still ends
   task automatic wait_ready(output int n, output bit saw_valid);
      n = 0;
      saw_valid = 1'b0;
      while (!ready && n < 100) begin
         if (dataValid) saw_valid = 1'b1;
         n++;
         @(negedge clock);
      end
   endtask

   initial begin
      int n;
      bit sv;

      vecs[0]  = '{1'b1, 1'b0, 8'd0,   8'h00, 1'b1, 1'b0, 8'h00};
      vecs[1]  = '{1'b1, 1'b0, 8'd15,  8'h00, 1'b1, 1'b0, 8'h00};
      vecs[2]  = '{1'b1, 1'b0, 8'd30,  8'h00, 1'b1, 1'b0, 8'h00};
      vecs[3]  = '{1'b0, 1'b0, 8'd0,   8'h00, 1'b0, 1'b0, 8'h00};
      vecs[4]  = '{1'b0, 1'b1, 8'd3,   8'hA5, 1'b0, 1'b0, 8'h00};
      vecs[5]  = '{1'b1, 1'b0, 8'd3,   8'h00, 1'b1, 1'b0, 8'hA5};
      vecs[6]  = '{1'b1, 1'b0, 8'd4,   8'h00, 1'b1, 1'b0, 8'h00};
      vecs[7]  = '{1'b1, 1'b1, 8'd7,   8'h3C, 1'b1, 1'b0, 8'h3C};
      vecs[8]  = '{1'b0, 1'b0, 8'd0,   8'h00, 1'b0, 1'b0, 8'h3C};
      vecs[9]  = '{1'b1, 1'b0, 8'd7,   8'h00, 1'b1, 1'b0, 8'h3C};
      vecs[10] = '{1'b0, 1'b1, 8'd30,  8'h66, 1'b0, 1'b0, 8'h3C};
      vecs[11] = '{1'b0, 1'b1, 8'd31,  8'hFF, 1'b0, 1'b1, 8'h3C};
      vecs[12] = '{1'b1, 1'b0, 8'd200, 8'h00, 1'b1, 1'b1, 8'h00};
      vecs[13] = '{1'b1, 1'b0, 8'd30,  8'h00, 1'b1, 1'b0, 8'h66};
      vecs[14] = '{1'b1, 1'b0, 8'd255, 8'h00, 1'b1, 1'b1, 8'h00};
      vecs[15] = '{1'b1, 1'b1, 8'd31,  8'h77, 1'b1, 1'b1, 8'h00};
      vecs[16] = '{1'b0, 1'b0, 8'd0,   8'h00, 1'b0, 1'b0, 8'h00};

      reset_n = 1'b1;
      clear   = 1'b0;
      drive(1'b0, 1'b0, 8'd0, 8'h00);
      #1 reset_n = 1'b0;
      #2;
      chk("rst_ready", ready, 0);
      chk("rst_valid", dataValid, 0);
      chk("rst_err", addrError, 0);
      chk("rst_dout", dataOut, 0);

      @(negedge clock);
      reset_n = 1'b1;
      wait_ready(n, sv);
      chk("fill_cycles", n, 31);
      chk("fill_no_valid", sv, 0);

      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
         @(negedge clock);
         chk($sformatf("vec%0d_valid", i), dataValid, vecs[i].valid);
         chk($sformatf("vec%0d_err", i), addrError, vecs[i].err);
         chk($sformatf("vec%0d_dout", i), dataOut, vecs[i].dout);
      end

      // Clear with a read held during the fill
      drive(1'b0, 1'b1, 8'd5, 8'h11);
      @(negedge clock);
      drive(1'b0, 1'b0, 8'd0, 8'h00);
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      drive(1'b1, 1'b0, 8'd5, 8'h00);
      wait_ready(n, sv);
      drive(1'b0, 1'b0, 8'd0, 8'h00);
      chk("clr_cycles", n, 31);
      chk("clr_no_valid", sv, 0);
      drive(1'b1, 1'b0, 8'd5, 8'h00);
      @(negedge clock);
      chk("clr_rd5_valid", dataValid, 1);
      chk("clr_rd5_dout", dataOut, 8'h00);
      drive(1'b1, 1'b0, 8'd3, 8'h00);
      @(negedge clock);
      chk("clr_rd3_dout", dataOut, 8'h00);

      // Reset while a read result is valid
      drive(1'b0, 1'b1, 8'd9, 8'h5A);
      @(negedge clock);
      drive(1'b1, 1'b0, 8'd9, 8'h00);
      @(negedge clock);
      chk("mr_valid_pre", dataValid, 1);
      chk("mr_dout_pre", dataOut, 8'h5A);
      drive(1'b0, 1'b0, 8'd0, 8'h00);
      #1 reset_n = 1'b0;
      #1;
      chk("mr_valid", dataValid, 0);
      chk("mr_dout", dataOut, 0);
      chk("mr_ready", ready, 0);
      @(negedge clock);
      reset_n = 1'b1;
      wait_ready(n, sv);
      chk("mr_fill_cycles", n, 31);

      // Reset in the middle of a fill must restart it from word 0
      drive(1'b0, 1'b1, 8'd25, 8'h5A);
      @(negedge clock);
      drive(1'b0, 1'b0, 8'd0, 8'h00);
      #1 reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      repeat (10) @(posedge clock);
      #3 reset_n = 1'b0;
      #1;
      chk("mf_ready", ready, 0);
      chk("mf_valid", dataValid, 0);
      chk("mf_dout", dataOut, 0);
      @(negedge clock);
      reset_n = 1'b1;
      wait_ready(n, sv);
      chk("mf_fill_cycles", n, 31);
      drive(1'b1, 1'b0, 8'd25, 8'h00);
      @(negedge clock);
      chk("mf_rd25_valid", dataValid, 1);
      chk("mf_rd25_dout", dataOut, 8'h00);
      drive(1'b0, 1'b0, 8'd0, 8'h00);
      @(negedge clock);
      chk("mf_idle_valid", dataValid, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
